// File: rtl/cla_slice_sequencer.sv
// ============================================================================
// cla_slice_sequencer : WORDS*16-bit adder built from one time-shared 16-bit
//                       carry-lookahead slice, least-significant slice first.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_slice_sequencer #(
  parameter int WORDS = 4,
  parameter int IDXW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy,
  output logic [IDXW-1:0]       slice_idx
);

  localparam int W = 16 * WORDS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [IDXW+3:0]   w_base;
  logic [15:0]       w_a, w_b, w_p, w_g, w_sum;
  logic [3:0]        w_pb, w_gb, w_gp, w_gg, w_gc;
  logic              w_cnx, w_cny, w_cnz, w_pbo, w_gbo, w_cout;
  logic [W-1:0]      w_mask;

  assign w_base = {idx_q, 4'b0000};
  assign w_a    = 16'(a_q >> w_base);
  assign w_b    = 16'(b_q >> w_base);
  assign w_p    = w_a ^ w_b;
  assign w_g    = w_a & w_b;

  // Each 4-bit group reports active-low P/G and ripples its sum bits from the
  // group carry supplied by the lookahead unit.
  for (genvar i = 0; i < 4; i++) begin : g_grp
    logic [3:0] p, g, c;
    assign p       = w_p[4*i +: 4];
    assign g       = w_g[4*i +: 4];
    assign w_pb[i] = ~&p;
    assign w_gb[i] = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                       (p[3] & p[2] & p[1] & g[0]));
    assign c[0]    = w_gc[i];
    for (genvar j = 0; j < 4; j++) begin : g_bit
      assign w_sum[4*i+j] = p[j] ^ c[j];
      if (j < 3) begin : g_rip
        assign c[j+1] = g[j] | (p[j] & c[j]);
      end
    end
  end

  assign w_gp  = ~w_pb;
  assign w_gg  = ~w_gb;
  assign w_cnx = w_gg[0] | (w_gp[0] & carry_q);
  assign w_cny = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & carry_q);
  assign w_cnz = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0]) |
                 (w_gp[2] & w_gp[1] & w_gp[0] & carry_q);
  assign w_gbo = ~(w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1]) |
                   (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]));
  assign w_pbo  = |w_pb;
  assign w_cout = ~w_gbo | (~w_pbo & carry_q);
  assign w_gc   = {w_cnz, w_cny, w_cnx, carry_q};

  assign w_mask = W'(16'hFFFF) << w_base;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~w_mask) | (W'(w_sum) << w_base);
        carry_d = w_cout;
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = w_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign slice_idx = idx_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_slice_sequencer.sv
// ============================================================================
// tb_cla_slice_sequencer : vector table, random operations against a+b+cin,
//                          backpressure and asynchronous-abort sequences.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cla_slice_sequencer;

  localparam int WORDS = 4;
  localparam int IDXW  = 4;
  localparam int W     = 16 * WORDS;

  logic            clk, rst_n, in_valid, in_ready, in_cin;
  logic [W-1:0]    in_a, in_b, out_sum;
  logic            out_valid, out_ready, out_cout, busy;
  logic [IDXW-1:0] slice_idx;

  cla_slice_sequencer #(.WORDS(WORDS), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .slice_idx (slice_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Carry into bit n of a+b+cin, from plain wide arithmetic.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic ci, input int n);
    logic [W:0] m, s;
    m = ((W+1)'(1) << n) - (W+1)'(1);
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(ci);
    return s[n];
  endfunction

  // Starts and finishes at a falling edge with the sequencer idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input int stall);
    check("in_ready_idle", W'(in_ready), W'(1'b1));
    in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    for (int s = 0; s < WORDS; s++) begin
      check("slice_idx", W'(slice_idx), W'(s));
      check("busy_run", W'(busy), W'(1'b1));
      check("out_valid_run", W'(out_valid), W'(1'b0));
      check("in_ready_run", W'(in_ready), W'(1'b0));
      check("carry_reg", W'(dut.carry_q), W'(carry_into(a, b, ci, 16*s)));
      check("cnx", W'(dut.w_cnx), W'(carry_into(a, b, ci, 16*s + 4)));
      check("cny", W'(dut.w_cny), W'(carry_into(a, b, ci, 16*s + 8)));
      check("cnz", W'(dut.w_cnz), W'(carry_into(a, b, ci, 16*s + 12)));
      in_valid = s[0];
      if (s < WORDS - 1) begin
        @(posedge clk); @(negedge clk);
      end
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("carry_reg_done", W'(dut.carry_q), W'(carry_into(a, b, ci, W)));
    for (int k = 0; k <= stall; k++) begin
      check("out_valid_done", W'(out_valid), W'(1'b1));
      check("out_sum", out_sum, exp_sum);
      check("out_cout", W'(out_cout), W'(exp_cout));
      check("in_ready_done", W'(in_ready), W'(1'b0));
      check("slice_idx_done", W'(slice_idx), W'(0));
      if (k < stall) begin
        in_valid = k[0];
        @(posedge clk); @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_idle", W'(out_valid), W'(1'b0));
    check("in_ready_after", W'(in_ready), W'(1'b1));
    check("busy_idle", W'(busy), W'(1'b0));
    check("out_sum_held", out_sum, exp_sum);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   r;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    tbl[1] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1};
    tbl[2] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
               64'h0001_0000_0001_0000, 1'b0};
    tbl[3] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cin = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out_sum", out_sum, '0);
    check("rst_out_cout", W'(out_cout), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_slice_idx", W'(slice_idx), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1'b1));

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, 0);

    // Backpressure: five stalled cycles in DONE with in_valid toggling.
    ra = 64'hDEAD_BEEF_0BAD_F00D; rb = 64'h1357_9BDF_2468_ACE0; rc = 1'b1;
    r = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
    run_op(ra, rb, rc, r[W-1:0], r[W], 5);

    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      r  = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, r[W-1:0], r[W], int'($urandom_range(0, 3)));
    end

    // Asynchronous abort in the middle of RUN.
    in_a = 64'hFFFF_0000_FFFF_0000; in_b = 64'h0001_0001_0001_0001; in_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 10 && slice_idx != IDXW'(2); t++) @(negedge clk);
    check("abort_idx2", W'(slice_idx), W'(2));
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), W'(1'b0));
    check("abort_out_sum", out_sum, '0);
    check("abort_out_cout", W'(out_cout), W'(1'b0));
    check("abort_busy", W'(busy), W'(1'b0));
    check("abort_slice_idx", W'(slice_idx), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
- Multi-cycle wide adder controller that time-shares one 16-bit carry-lookahead slice across a WORDS*16-bit operand.
- The slice is four 4-bit groups feeding an internal 74182-equivalent group lookahead: active-low group P/G in, active-high CN in, CNX/CNY/CNZ group carries, active-low PBo/GBo out.
- The sequencer accepts an operand pair over a valid/ready handshake and processes one 16-bit slice per cycle, least-significant slice first. It registers the inter-slice carry and returns the full sum over a valid/ready handshake.

Parameters:
- WORDS, 4, number of 16-bit slices; W = 16*WORDS is the operand width; legal range 1..16.
- IDXW, 4, width of the slice index; must satisfy 2^IDXW >= WORDS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  sequencer can accept a pair (IDLE only).
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into bit 0, active high.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  W  registered sum.
- out_cout  output  1  carry out of bit W-1.
- busy  output  1  high in RUN or DONE.
- slice_idx  output  IDXW  slice being processed in RUN; 0 otherwise.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1 once rst_n is high; out_valid=0, out_sum=0, out_cout=0, busy=0, slice_idx=0; operand and carry registers cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a, in_b; carry_reg<=in_cin; slice_idx<=0; go to RUN.
  - out_valid=0.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, slice s=slice_idx uses bits [16s+15:16s].
  - Per group i: p=a^b, g=a&b; PB[i]=~&p; GB[i]=~|(g | p&lower-ripple).
    - Group G uses standard 4-bit generate: g3|p3g2|p3p2g1|p3p2p1g0.
  - Lookahead equations (CN=carry_reg):
    - CNX = G0|P0·CN
    - CNY = G1|P1G0|P1P0·CN
    - CNZ = G2|P2G1|P2P1G0|P2P1P0·CN
  - Slice carry-out = ~GBo | (~PBo & CN). PBo is the OR of the PB inputs, i.e. active-low AND of the group P's.
  - Each group ripples its 4 sum bits from its group carry-in (CN, CNX, CNY, CNZ).
  - Sum slice is written into the result register; carry_reg<=slice carry-out; slice_idx<=slice_idx+1.
  - When slice_idx==WORDS-1: out_cout<=slice carry-out, slice_idx<=0, go to DONE.
  - With WORDS=1, RUN lasts exactly one cycle.
- DONE:
  - out_valid=1; out_sum and out_cout stay stable while out_ready=0.
  - On out_ready: go to IDLE.
  - No new operand is accepted in the same cycle as the result handshake.
- Latency: accept edge at cycle k; out_valid rises after edge k+WORDS. Throughput is one operation per WORDS+2 cycles when out_ready is held high.
- out_sum and out_cout keep the last result in IDLE until the next operation writes them. out_sum is updated slice-by-slice during RUN.
- Reset asserted mid-RUN or in DONE aborts the operation; every output returns to its reset value and the partial result is discarded.
- Arithmetic is modulo 2^W. No overflow flag; signed interpretation is the consumer's responsibility.

Test Plan:
- Reset → out_valid=0, out_sum=0, out_cout=0, busy=0, slice_idx=0, in_ready=1 on the first cycle after rst_n rises.
- WORDS=4, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → out_sum=0, out_cout=1, out_valid 4 cycles after the accept edge; slice_idx steps 0,1,2,3.
- A=0x0123_4567_89AB_CDEF, B=0xFEDC_BA98_7654_3210, cin=1 → out_sum=0, out_cout=1. Also check CNX=CNY=CNZ=1 on every slice.
- A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001, cin=0 → out_sum=0x0001_0000_0001_0000, out_cout=0. Also check that carry_reg toggles 1,0,1,0 across the slices.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid pulses → out_valid, out_sum and out_cout stay stable and in_ready=0. After out_ready=1 for one cycle → IDLE, in_ready=1.
- Drop rst_n asynchronously at slice_idx=2 → all outputs reset immediately. A following A=5, B=7, cin=0 then yields out_sum=12, out_cout=0.
